avmm_ram_test_master: RTL
=========================

Name: avmm_ram_test_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave from the initiator side.
- On `start` it runs a write phase over a word range, then a read-back-and-compare phase, then reports a mismatch count and the first failing address.
- Used for built-in RAM self-test and bring-up; it connects directly to the RAM slave port, or through the interconnect.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed slave read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address
- num_words  in  ADDR_W+1  word count; values above 2^ADDR_W clamp to 2^ADDR_W
- seed  in  DATA_W  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- error_count  out  ADDR_W+1  number of mismatches in the last run
- first_err_addr  out  ADDR_W  address of the first mismatch, 0 if none
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  equals avm_read | avm_write
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  DATA_W/8  all ones whenever a request is asserted, else 0
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, and is named `reset` on clock `clk`.
- Reset values: all outputs are 0, and the FSM is in IDLE.
- Pattern: word i (0 ≤ i < N) is written at address (base_addr + i) mod 2^ADDR_W.
  - Data for word i is (seed + i) mod 2^DATA_W.
  - Address wrap-around is legal.
- FSM states: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE:
  - start=1 with N>0 → WRITE; busy=1 from the next cycle.
  - start=1 with N=0 → FIN.
  - On any start, error_count and first_err_addr clear to 0.
- WRITE:
  - avm_write=1, with address and data for the current i.
  - A transfer is accepted in a cycle where avm_waitrequest=0; i then advances.
  - While waitrequest=1, address, data, byteenable and write hold stable.
  - After the last write is accepted, the next cycle enters READ with i=0.
- READ:
  - avm_read=1 for each i, with the same acceptance rule as WRITE.
  - Reads are pipelined: a new read may be issued every cycle.
  - Each accepted read pushes {valid, expected data, address} into a READ_LATENCY-deep shift pipeline.
  - avm_readdata is sampled exactly READ_LATENCY cycles after the acceptance cycle.
  - After the last read is accepted → DRAIN.
- DRAIN: no request is asserted. When the pipeline is empty → FIN.
- Compare:
  - On a mismatch, error_count increments.
  - If error_count was 0 before the increment, first_err_addr captures that address.
  - error_count cannot overflow, since N ≤ 2^ADDR_W.
- FIN: done=1 and busy=0 for exactly one cycle, then → IDLE. Results hold until the next start.
- avm_read and avm_write are never both 1.
- start is ignored while the FSM is not in IDLE.
- Timing (start at cycle T, waitrequest=0 throughout):
  - writes occur at T+1..T+N;
  - reads occur at T+N+1..T+2N;
  - done pulses at T+2N+READ_LATENCY+1;
  - with N=0, done pulses at T+1.
- Reset mid-operation: in the cycle after reset is sampled, all requests drop, busy, done and the counters are 0, and in-flight read data is discarded. A new start is accepted immediately after reset deasserts.

Test Plan:
- RAM model with READ_LATENCY=1 and waitrequest=0; base=0, N=16, seed=0xA5A50000, start at T.
  - Expect writes of 0xA5A50000..0xA5A5000F to addresses 0..15 at T+1..T+16.
  - Expect reads at T+17..T+32 and done at T+34.
  - Expect error_count=0 and first_err_addr=0.
- Wrap-around: base=0x3FE, N=4, seed=0x10.
  - Expect addresses 0x3FE, 0x3FF, 0x000, 0x001 with data 0x10..0x13.
  - Expect error_count=0.
- Fault injection: the model flips bit 0 on reads of addresses 5 and 9 (N=16, base=0).
  - Expect error_count=2 and first_err_addr=5.
- Random 50% waitrequest, with READ_LATENCY=3 in both DUT and model.
  - Request signals stay stable through every stall.
  - Exactly N writes and N reads are accepted.
  - error_count=0.
- N=0 → done at T+1 with no avm_read/avm_write activity.
- start pulsed during WRITE → ignored; the run completes once.
- Reset asserted mid-READ:
  - next cycle, avm_read=0, busy=0 and error_count=0;
  - a subsequent start with N=8 completes normally with error_count=0.

Source files
------------

// File: rtl/avmm_ram_test_master_if.sv
// rtl/avmm_ram_test_master_if.sv - Avalon-MM bus between the RAM test master and the RAM slave
interface avmm_ram_test_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/avmm_ram_test_master.sv
// rtl/avmm_ram_test_master.sv - write/read-back RAM self-test master on Avalon-MM
module avmm_ram_test_master #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_words,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       error_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    avmm_ram_test_master_if.master avm
);
    localparam logic [ADDR_W:0]       N_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [READ_LATENCY-1:0] EARLY_MASK = READ_LATENCY'((1 << (READ_LATENCY - 1)) - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_t;

    state_t                r_state, w_next;
    logic [ADDR_W:0]       r_idx, r_n;
    logic [ADDR_W-1:0]     r_base;
    logic [DATA_W-1:0]     r_seed;
    logic [ADDR_W:0]       r_err_cnt;
    logic [ADDR_W-1:0]     r_first_err;
    logic [READ_LATENCY-1:0] r_pv;
    logic [DATA_W-1:0]     r_pd [READ_LATENCY];
    logic [ADDR_W-1:0]     r_pa [READ_LATENCY];

    logic                  w_wr_req, w_rd_req, w_req, w_accept, w_last;
    logic                  w_inflight, w_mismatch;
    logic [ADDR_W:0]       w_n_clamped;
    logic [ADDR_W-1:0]     w_cur_addr;
    logic [DATA_W-1:0]     w_cur_data;

    assign w_n_clamped = (num_words > N_MAX) ? N_MAX : num_words;
    assign w_cur_addr  = r_base + r_idx[ADDR_W-1:0];
    assign w_cur_data  = r_seed + DATA_W'(r_idx);
    assign w_req       = w_wr_req | w_rd_req;
    assign w_accept    = w_req & ~avm.avm_waitrequest;
    assign w_last      = (r_idx == r_n - 1'b1);
    // The oldest stage is compared this cycle, so only younger stages keep DRAIN alive.
    assign w_inflight  = |(r_pv & EARLY_MASK);
    assign w_mismatch  = r_pv[READ_LATENCY-1] && (avm.avm_readdata != r_pd[READ_LATENCY-1]);

    assign avm.avm_read       = w_rd_req;
    assign avm.avm_write      = w_wr_req;
    assign avm.avm_chipselect = w_req;
    assign avm.avm_byteenable = w_req ? '1 : '0;
    assign avm.avm_address    = w_req ? w_cur_addr : '0;
    assign avm.avm_writedata  = w_wr_req ? w_cur_data : '0;

    assign error_count    = r_err_cnt;
    assign first_err_addr = r_first_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_wr_req = 1'b0;
        w_rd_req = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_n_clamped == '0) ? S_FIN : S_WRITE;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                w_wr_req = 1'b1;
                if (w_accept && w_last) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                w_rd_req = 1'b1;
                if (w_accept && w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!w_inflight) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_n         <= '0;
            r_base      <= '0;
            r_seed      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pv        <= '0;
        end else begin
            r_pv <= (r_pv << 1) | READ_LATENCY'(w_rd_req & w_accept);
            if (r_state == S_IDLE && start) begin
                r_idx       <= '0;
                r_n         <= w_n_clamped;
                r_base      <= base_addr;
                r_seed      <= seed;
                r_err_cnt   <= '0;
                r_first_err <= '0;
            end else begin
                if (w_accept) begin
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                if (w_mismatch) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                    if (r_err_cnt == '0) begin
                        r_first_err <= r_pa[READ_LATENCY-1];
                    end
                end
            end
        end
    end

    // Payload stages need no reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        r_pd[0] <= w_cur_data;
        r_pa[0] <= w_cur_addr;
        for (int k = READ_LATENCY - 1; k > 0; k--) begin
            r_pd[k] <= r_pd[k-1];
            r_pa[k] <= r_pa[k-1];
        end
    end
endmodule
